// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_pkg                                                                     |
// | Shared state encoding and constants for the serial pattern transmitter.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } seq_tx_state_t;

   localparam logic [4:0] SEQ_DEFAULT_PAT = 5'b11011;
   localparam int         SEQ_REPS_W      = 4;

endpackage
`default_nettype wire

// File: rtl/seq_tx_shreg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_tx_shreg                                                                |
// | Parallel-load pattern store with a down-counting bit index. With the        |
// | SEQ_TX_PARITY_EN macro defined it also keeps a running frame parity.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module seq_tx_shreg
   import seq_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LW      = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               reload_i,
   input  logic               step_i,
   input  logic [MAX_LEN-1:0] pattern_i,
   input  logic [LW-1:0]      len_m1_i,
   output logic               idx_zero_o,
   output logic               nxt_bit_o,
   output logic               nxt_last_o
`ifdef SEQ_TX_PARITY_EN
   ,
   output logic               parity_o
`endif
);

   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LW-1:0]      len_q, len_d;
   logic [LW-1:0]      idx_q, idx_d;

   // The *_d values describe the bit that will be on the line next cycle.
   always_comb begin
      pat_d = pat_q;
      len_d = len_q;
      idx_d = idx_q;
      if (load_i) begin
         pat_d = pattern_i;
         len_d = len_m1_i;
         idx_d = len_m1_i;
      end else if (reload_i) begin
         idx_d = len_q;
      end else if (step_i) begin
         idx_d = idx_q - 1'b1;
      end
   end

   assign nxt_bit_o  = pat_d[idx_d];
   assign nxt_last_o = (idx_d == '0);
   assign idx_zero_o = (idx_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q <= '0;
         len_q <= '0;
         idx_q <= '0;
      end else begin
         pat_q <= pat_d;
         len_q <= len_d;
         idx_q <= idx_d;
      end
   end

`ifdef SEQ_TX_PARITY_EN
   logic par_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else if (load_i || reload_i) begin
         par_q <= nxt_bit_o;
      end else if (step_i) begin
         par_q <= par_q ^ nxt_bit_o;
      end
   end

   assign parity_o = par_q;
`endif

endmodule
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_pattern_tx                                                              |
// | Repeating MSB-first serial pattern transmitter with idle gaps. Define       |
// | SEQ_TX_PARITY_EN to append an even-parity bit to every frame.               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int MAX_LEN    = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [MAX_LEN-1:0]         pattern,
   input  logic [$clog2(MAX_LEN)-1:0] len_m1,
   input  logic [SEQ_REPS_W-1:0]      reps,
   output logic                       ready,
   output logic                       ser_out,
   output logic                       ser_valid,
   output logic                       frame_end,
   output logic                       done
);

   localparam int LW = $clog2(MAX_LEN);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   seq_tx_state_t         state_q;
   logic [SEQ_REPS_W-1:0] reps_left_q;
   logic [GW-1:0]         gap_cnt_q;
   logic                  ready_q, ser_out_q, ser_valid_q, frame_end_q, done_q;

   logic w_load, w_reload, w_step, w_more, w_frame_done;
   logic w_idx_zero, w_nxt_bit, w_nxt_last, w_bit_fe;

`ifdef SEQ_TX_PARITY_EN
   logic par_phase_q;
   logic w_parity;
   assign w_frame_done = w_idx_zero && par_phase_q;
   assign w_bit_fe     = 1'b0;
`else
   assign w_frame_done = w_idx_zero;
   assign w_bit_fe     = w_nxt_last;
`endif

   assign w_more   = (reps_left_q != '0);
   assign w_load   = (state_q == IDLE) && start;
   assign w_step   = (state_q == SEND) && !w_idx_zero;
   assign w_reload = ((state_q == SEND) && w_frame_done && w_more && (GAP_CYCLES == 0)) ||
                     ((state_q == GAP) && (gap_cnt_q == '0));

   seq_tx_shreg #(
      .MAX_LEN (MAX_LEN),
      .LW      (LW)
   ) u_shreg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (w_load),
      .reload_i   (w_reload),
      .step_i     (w_step),
      .pattern_i  (pattern),
      .len_m1_i   (len_m1),
      .idx_zero_o (w_idx_zero),
      .nxt_bit_o  (w_nxt_bit),
      .nxt_last_o (w_nxt_last)
`ifdef SEQ_TX_PARITY_EN
      ,
      .parity_o   (w_parity)
`endif
   );

   // Outputs are loaded with what the line must show in the cycle after each edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         reps_left_q <= '0;
         gap_cnt_q   <= '0;
         ready_q     <= 1'b1;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         frame_end_q <= 1'b0;
         done_q      <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
         par_phase_q <= 1'b0;
`endif
      end else begin
         ready_q     <= 1'b0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         frame_end_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= SEND;
                  reps_left_q <= reps;
                  ser_out_q   <= w_nxt_bit;
                  ser_valid_q <= 1'b1;
                  frame_end_q <= w_bit_fe;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            SEND: begin
               if (!w_frame_done) begin
`ifdef SEQ_TX_PARITY_EN
                  if (w_idx_zero) begin
                     par_phase_q <= 1'b1;
                     ser_out_q   <= w_parity;
                     ser_valid_q <= 1'b1;
                     frame_end_q <= 1'b1;
                  end else begin
                     ser_out_q   <= w_nxt_bit;
                     ser_valid_q <= 1'b1;
                     frame_end_q <= w_bit_fe;
                  end
`else
                  ser_out_q   <= w_nxt_bit;
                  ser_valid_q <= 1'b1;
                  frame_end_q <= w_bit_fe;
`endif
               end else begin
`ifdef SEQ_TX_PARITY_EN
                  par_phase_q <= 1'b0;
`endif
                  if (w_more) begin
                     reps_left_q <= reps_left_q - 1'b1;
                     if (GAP_CYCLES == 0) begin
                        ser_out_q   <= w_nxt_bit;
                        ser_valid_q <= 1'b1;
                        frame_end_q <= w_bit_fe;
                     end else begin
                        state_q   <= GAP;
                        gap_cnt_q <= GW'(GAP_CYCLES - 1);
                     end
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_q == '0) begin
                  state_q     <= SEND;
                  ser_out_q   <= w_nxt_bit;
                  ser_valid_q <= 1'b1;
                  frame_end_q <= w_bit_fe;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ready     = ready_q;
   assign ser_out   = ser_out_q;
   assign ser_valid = ser_valid_q;
   assign frame_end = frame_end_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_pattern_tx                                                           |
// | Scoreboard bench: directed frames push per-cycle expectations, a monitor    |
// | compares every cycle. Honours SEQ_TX_PARITY_EN like the design.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_seq_pattern_tx;
   import seq_pkg::*;

   localparam int GAP = 2;
`ifdef SEQ_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   // One observed/expected cycle: ready, ser_valid, ser_out, frame_end, done.
   typedef struct packed {
      logic rdy;
      logic vld;
      logic so;
      logic fe;
      logic dn;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] pattern = '0;
   logic [2:0] len_m1 = '0;
   logic [3:0] reps = '0;
   logic       ready, ser_out, ser_valid, frame_end, done;

   obs_t       exp_q[$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         hits = 0;
   logic [4:0] hist = '0;

   seq_pattern_tx #(
      .MAX_LEN    (8),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .pattern   (pattern),
      .len_m1    (len_m1),
      .reps      (reps),
      .ready     (ready),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .frame_end (frame_end),
      .done      (done)
   );

   always #5 clk = ~clk;

   // With nothing queued the transmitter must sit idle: ready high, rest low.
   always @(negedge clk) begin
      obs_t e;
      obs_t a;
      if (rst_n) begin
         e = obs_t'(5'b10000);
         if (exp_q.size() != 0) e = exp_q.pop_front();
         a = {ready, ser_valid, ser_out, frame_end, done};
         n_chk++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL stream @%0t: got rdy,vld,so,fe,dn=%b required %b", $time, a, e);
         end
         hist = {hist[3:0], ser_out};
         if (hist == SEQ_DEFAULT_PAT) hits++;
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0b required %0b", nm, act, req);
      end
   endtask

   task automatic push_frames(input string bits, input bit pbit, input int nreps);
      int   L;
      logic b;
      L = bits.len();
      for (int r = 0; r <= nreps; r++) begin
         for (int i = 0; i < L; i++) begin
            b = (bits[i] == "1");
            exp_q.push_back(obs_t'({1'b0, 1'b1, b, (!PAR && i == L - 1), 1'b0}));
         end
         if (PAR) exp_q.push_back(obs_t'({1'b0, 1'b1, pbit, 1'b1, 1'b0}));
         if (r < nreps)
            for (int g = 0; g < GAP; g++) exp_q.push_back(obs_t'(5'b00000));
      end
      exp_q.push_back(obs_t'(5'b00001));
      exp_q.push_back(obs_t'(5'b10000));
   endtask

   // Called at posedge+1. Issues start in the first cycle the DUT shows ready.
   task automatic send(input logic [7:0] pat, input logic [2:0] lm1, input logic [3:0] nr,
                       input string bits, input bit pbit);
      int t;
      t = 0;
      while ((exp_q.size() > 1 || ready !== 1'b1) && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 300) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_ready: got ready=%b queued=%0d required ready=1", ready, exp_q.size());
      end
      start   = 1'b1;
      pattern = pat;
      len_m1  = lm1;
      reps    = nr;
      @(posedge clk);
      #1;
      start = 1'b0;
      push_frames(bits, pbit, int'(nr));
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 300) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: got queued=%0d required 0", exp_q.size());
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", int'(ready), 1);
      chk("reset_ser_out", int'(ser_out), 0);
      chk("reset_ser_valid", int'(ser_valid), 0);
      chk("reset_frame_end", int'(frame_end), 0);
      chk("reset_done", int'(done), 0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      send(8'b0001_1011, 3'd4, 4'd0, "11011", 1'b0);

      // Busy start with new operands must neither queue nor disturb the frame.
      send(8'b0001_1011, 3'd4, 4'd0, "11011", 1'b0);
      start   = 1'b1;
      pattern = 8'hFF;
      len_m1  = 3'd7;
      reps    = 4'd15;
      @(posedge clk);
      #1;
      start = 1'b0;

      send(8'b0001_1011, 3'd4, 4'd2, "11011", 1'b0);

      // Asynchronous reset right after the second bit.
      send(8'b0001_1011, 3'd4, 4'd0, "11011", 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midreset_outputs", int'({ready, ser_valid, ser_out, frame_end, done}), 5'b10000);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'b0001_1011, 3'd4, 4'd0, "11011", 1'b0);

      send(8'hA5, 3'd7, 4'd0, "10100101", 1'b0);
      send(8'h01, 3'd0, 4'd0, "1", 1'b1);
      send(8'b0001_0011, 3'd4, 4'd1, "10011", 1'b1);
      drain();

      if (PAR) begin
         hits = 0;
         send(8'b0001_1011, 3'd4, 4'd0, "11011", 1'b0);
         drain();
         repeat (3) @(posedge clk);
         #1;
         chk("loopback_hits", hits, 1);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial bit-pattern transmitter: the generating end of the serial bitstream that the Mealy sequence detector consumes. It captures a pattern of 1..8 bits, shifts it out MSB-first one bit per clock, and repeats the frame a programmable number of times with idle gap cycles between frames. It sits in front of the detector's `ui_in[0]` input so the detector can be driven on-chip by a known stream, for example the 11011 target.

## Interface
- `MAX_LEN`, default 8: maximum frame length in bits; the `len_m1` width is `$clog2(MAX_LEN)`.
- `GAP_CYCLES`, default 2: idle cycles between repeated frames; 0 means back-to-back frames.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to transmit; accepted only when `ready`=1.
- `pattern`  in  MAX_LEN  frame bits; bit `len_m1` is sent first, bit 0 last.
- `len_m1`  in  $clog2(MAX_LEN)  frame length minus one (1..MAX_LEN bits).
- `reps`  in  4  number of extra frames; total frames = `reps`+1.
- `ready`  out  1  high in IDLE only.
- `ser_out`  out  1  serial data bit; 0 whenever `ser_valid`=0.
- `ser_valid`  out  1  `ser_out` carries a frame bit this cycle.
- `frame_end`  out  1  high with the final bit of each frame.
- `done`  out  1  one-cycle pulse after the final frame.

## Operation
- States: IDLE, SEND, GAP, DONE.
- **IDLE:** `ready`=1 and all other outputs are 0.
  - `start`=1 latches `pattern`, `len_m1` and `reps`, sets `bit_idx`=`len_m1` and `reps_left`=`reps`, then moves to SEND.
- **SEND:** drives `ser_out`=`pat_q[bit_idx]` with `ser_valid`=1, and decrements `bit_idx` each cycle.
  - At `bit_idx`=0, `frame_end`=1.
  - If `reps_left`>0: decrement `reps_left` and go to GAP, or straight back to SEND when `GAP_CYCLES`=0.
  - Otherwise go to DONE.
- **GAP:** holds `ser_valid`=0 for exactly `GAP_CYCLES` cycles, then reloads `bit_idx`=`len_q` and returns to SEND.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `start` while `ready`=0 is ignored and is not queued.
- Changes on `pattern`, `len_m1` or `reps` after acceptance have no effect on the frame in progress.
- The bit index counts down only; it never wraps, because reload happens only at a frame boundary.
- **Reset mid-operation:** the state returns to IDLE immediately.
  - `ser_out`, `ser_valid`, `frame_end` and `done` go to 0 immediately.
  - `ready` goes to 1.
  - No partial frame resumes after reset.

## Timing
- **Reset values:** `ready`=1; `ser_out`, `ser_valid`, `frame_end`, `done` = 0.
- All outputs are registered.
  - `start` sampled at edge N puts the first bit on `ser_out` in cycle N+1.
  - `ready` drops in that same cycle N+1.
- A frame of L = `len_m1`+1 bits occupies L consecutive `ser_valid` cycles.
- Total active span = (`reps`+1)·L + `reps`·`GAP_CYCLES` cycles.
- `done` is asserted in the cycle after the last bit; `ready` is high in the following cycle.
- The earliest back-to-back restart is a `start` sampled in the first `ready` cycle.

## Configuration
- The feature is selected by the macro `SEQ_TX_PARITY_EN`.
- **Defined:**
  - Each frame is followed by one even-parity bit: the XOR of the frame's L bits, with `ser_valid`=1.
  - `frame_end` moves to the parity bit.
  - The frame length becomes L+1 in all timing formulas.
- **Undefined:** no parity bit and no parity logic.

## Structure
- Package `seq_pkg` holds:
  - the state enum `seq_tx_state_t` (IDLE, SEND, GAP, DONE);
  - `SEQ_DEFAULT_PAT` = 5'b11011;
  - `SEQ_REPS_W` = 4.
- Sub-module `seq_tx_shreg`:
  - parallel-load shift register with a down-counting bit index;
  - when `SEQ_TX_PARITY_EN` is defined, also a running-parity accumulator;
  - the top level holds the FSM, `reps_left` and the gap counter.

## Test plan
- **Basic frame:** reset, then `start` with `pattern`=8'b0001_1011, `len_m1`=4, `reps`=0.
  - `ser_out` = 1,1,0,1,1 in cycles N+1..N+5.
  - `frame_end` in cycle N+5, `done` in N+6, `ready` in N+7.
- **Repeats with gaps:** `reps`=2, `GAP_CYCLES`=2, same pattern.
  - Three 5-bit frames separated by two `ser_valid`=0 cycles: 19 active cycles, then `done`.
- **Start while busy:** `start` with 8'hFF asserted during the first frame.
  - It is ignored, and the stream is identical to the basic-frame case.
- **Async reset mid-frame:** assert reset after the 2nd bit.
  - Outputs go to 0 and `ready`=1 immediately.
  - A fresh `start` transmits a full frame from the MSB.
- **Length extremes:**
  - `len_m1`=7, `pattern`=8'hA5 → 1,0,1,0,0,1,0,1.
  - `len_m1`=0, `pattern[0]`=1 → single bit with `frame_end`.
- **Parity (`SEQ_TX_PARITY_EN` defined):**
  - Pattern 11011 → parity bit 0 appended, `frame_end` on the 6th bit.
  - Pattern 10011 → parity bit 1.
  - Loopback into the 11011 detector: the first 11011 frame fires the detector exactly once.
